// File: rtl/pc_unit.sv
`default_nettype none
// ============================================================================
// Module   : pc_unit
// Brief    : Fetch-stage program counter with next-PC select, stall hold,
//            exception redirect/EPC capture and a circular return-address stack.
// Revision : 1.0 - initial release
// ============================================================================
module pc_unit #(
    parameter int              XLEN         = 32,
    parameter int              RAS_DEPTH    = 4,
    parameter logic [31:0]     RESET_VECTOR = 32'h0000_3000,
    parameter logic [31:0]     EXC_VECTOR   = 32'h0000_4180
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         stall,
    input  logic [2:0]                   npc_op,
    input  logic [25:0]                  imm,
    input  logic [XLEN-1:0]              rd1,
    input  logic                         link,
    input  logic                         exc_req,
    output logic [XLEN-1:0]              pc,
    output logic [XLEN-1:0]              npc,
    output logic [XLEN-1:0]              epc,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic                         ras_miss
);

    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [2:0] c_op_plus4  = 3'b000;
    localparam logic [2:0] c_op_branch = 3'b001;
    localparam logic [2:0] c_op_jump   = 3'b010;
    localparam logic [2:0] c_op_reg    = 3'b011;
    localparam logic [2:0] c_op_ret    = 3'b100;
    localparam logic [2:0] c_op_eret   = 3'b101;

    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_epc;
    logic [XLEN-1:0] r_ras [RAS_DEPTH];
    logic [PW-1:0]   r_ptr;
    logic [CW-1:0]   r_count;
    logic            r_miss;

    logic [XLEN-1:0] w_pcplus4;
    logic [XLEN-1:0] w_branch_tgt;
    logic [XLEN-1:0] w_jump_tgt;
    logic [PW-1:0]   w_ptr_dec;
    logic            w_ras_empty;
    logic            w_push;
    logic            w_pop;
    logic            w_miss;
    logic            w_advance;

    assign w_pcplus4    = r_pc + XLEN'(4);
    assign w_branch_tgt = w_pcplus4 + {{(XLEN-18){imm[15]}}, imm[15:0], 2'b00};
    assign w_jump_tgt   = {w_pcplus4[XLEN-1:28], imm, 2'b00};
    assign w_ptr_dec    = r_ptr - 1'b1;
    assign w_ras_empty  = (r_count == '0);

    assign w_push    = ((npc_op == c_op_jump) || (npc_op == c_op_reg)) && link;
    assign w_pop     = (npc_op == c_op_ret) && !w_ras_empty;
    assign w_miss    = (npc_op == c_op_ret) && w_ras_empty;
    assign w_advance = !exc_req && !stall;

    always_comb begin
        npc = w_pcplus4;
        case (npc_op)
            c_op_branch: npc = w_branch_tgt;
            c_op_jump:   npc = w_jump_tgt;
            c_op_reg:    npc = rd1;
            c_op_ret:    npc = w_ras_empty ? rd1 : r_ras[w_ptr_dec];
            c_op_eret:   npc = r_epc;
            default:     npc = w_pcplus4;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pc    <= XLEN'(RESET_VECTOR);
            r_epc   <= '0;
            r_ptr   <= '0;
            r_count <= '0;
            r_miss  <= 1'b0;
        end else if (exc_req) begin
            r_pc   <= XLEN'(EXC_VECTOR);
            r_epc  <= r_pc;
            r_miss <= 1'b0;
        end else if (stall) begin
            r_miss <= 1'b0;
        end else begin
            r_pc   <= npc;
            r_miss <= w_miss;
            if (w_push) begin
                r_ptr <= r_ptr + 1'b1;
                // Full stack keeps its count; the write wraps onto the oldest entry.
                if (r_count != CW'(RAS_DEPTH)) begin
                    r_count <= r_count + 1'b1;
                end
            end else if (w_pop) begin
                r_ptr   <= w_ptr_dec;
                r_count <= r_count - 1'b1;
            end
        end
    end

    // Entry storage carries no reset; validity is tracked by r_count alone.
    always_ff @(posedge clk) begin
        if (!rst && w_advance && w_push) begin
            r_ras[r_ptr] <= w_pcplus4;
        end
    end

    assign pc        = r_pc;
    assign epc       = r_epc;
    assign ras_count = r_count;
    assign ras_miss  = r_miss;

endmodule
`default_nettype wire
